// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU sequencer.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [1:0] ALUOP_R = 2'b01;
  localparam logic [1:0] ALUOP_I = 2'b00;

  // Opcodes the datapath can execute; anything else traps.
  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_ITYPE);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive stalled fetch cycles and flags the one that uses up the budget.
module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q;

  // Stall counter: cleared on any ack or outside FETCH, advances on each stalled cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      cnt_q <= '0;
    else if (clr)    cnt_q <= '0;
    else if (en)     cnt_q <= cnt_q + 1'b1;
  end

  // Combinational so the FSM can leave FETCH in the same cycle the count reaches the limit.
  assign expire = en && !clr && (cnt_q == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Fetch/decode/execute/write-back sequencer with illegal-opcode and fetch-stall traps.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  input  logic [31:0]      inst_i,
  output logic             IRWrite_o,
  output logic             PCWrite_o,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e     state_q, state_d;
  logic [6:0] op_q;
  logic       wd_clr, wd_en, wd_expire;
  logic       in_fetch;

  // Only the opcode field steers the sequencer; the rest belongs to the datapath.
  logic unused_inst;
  assign unused_inst = ^inst_i[31:7];

  assign in_fetch = (state_q == S_FETCH);
  assign wd_clr   = !in_fetch || imem_ack_i;
  assign wd_en    = in_fetch && !imem_ack_i;

  fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an ack in the last allowed fetch cycle beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack_i)     state_d = S_DECODE;
        else if (wd_expire) state_d = S_HALT;
      end
      S_DECODE: state_d = op_legal(op_q) ? S_EXEC : S_HALT;
      S_EXEC:   state_d = S_WB;
      S_WB:     state_d = start_i ? S_FETCH : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Opcode capture, sticky trap flags and retired-instruction counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      op_q      <= '0;
      illegal_o <= 1'b0;
      timeout_o <= 1'b0;
      retired_o <= '0;
    end else begin
      if (in_fetch && imem_ack_i)                     op_q      <= inst_i[6:0];
      if (in_fetch && !imem_ack_i && wd_expire)       timeout_o <= 1'b1;
      if (state_q == S_DECODE && !op_legal(op_q))     illegal_o <= 1'b1;
      if (state_q == S_WB)                            retired_o <= retired_o + CNT_W'(1);
    end
  end

  // Control outputs: Moore on state/op_q, except IRWrite which follows the ack directly.
  always_comb begin
    imem_req_o = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    RegWrite_o = 1'b0;
    ALUOp_o    = 2'b00;
    ALUSrc_o   = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_o = 1'b1;
        IRWrite_o  = imem_ack_i;
        busy_o     = 1'b1;
      end
      S_DECODE: busy_o = 1'b1;
      S_EXEC: begin
        ALUOp_o  = op_q[6:5];
        ALUSrc_o = ~op_q[5];
        busy_o   = 1'b1;
      end
      S_WB: begin
        ALUOp_o    = op_q[6:5];
        ALUSrc_o   = ~op_q[5];
        RegWrite_o = 1'b1;
        PCWrite_o  = 1'b1;
        busy_o     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed + randomized bench for multicycle_ctrl, checked against a phase-level model.
module tb_multicycle_ctrl;

  localparam logic [31:0] ADD  = 32'h00208033;
  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] LOAD = 32'h00002003;
  localparam logic [6:0]  OPR  = 7'b0110011;
  localparam logic [6:0]  OPI  = 7'b0010011;
  localparam int          TO   = 16;

  logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, imem_ack_i = 1'b0;
  logic [31:0] inst_i = '0;

  logic        imem_req_o, IRWrite_o, PCWrite_o, ALUSrc_o, RegWrite_o, busy_o, illegal_o, timeout_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] retired_o;
  logic        req4, irw4, pcw4, src4, regw4, busy4, ill4, to4;
  logic [1:0]  aluop4;
  logic [3:0]  retired4;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .inst_i(inst_i),
    .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o),
    .RegWrite_o(RegWrite_o), .busy_o(busy_o), .illegal_o(illegal_o), .timeout_o(timeout_o),
    .retired_o(retired_o)
  );

  multicycle_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(req4), .imem_ack_i(imem_ack_i), .inst_i(inst_i),
    .IRWrite_o(irw4), .PCWrite_o(pcw4), .ALUOp_o(aluop4), .ALUSrc_o(src4),
    .RegWrite_o(regw4), .busy_o(busy4), .illegal_o(ill4), .timeout_o(to4),
    .retired_o(retired4)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0, errors = 0;
  int unsigned m_ret;
  bit          m_ill, m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {req, irwrite, pcwrite, regwrite, aluop[1:0], alusrc, busy} per phase:
  // 0 idle/halt, 1 fetch, 2 decode, 3 exec, 4 write-back.
  function automatic logic [7:0] exp_ctl(input int ph, input bit ack, input bit is_r);
    logic [1:0] aop;
    logic       src;
    aop = is_r ? 2'b01 : 2'b00;
    src = !is_r;
    case (ph)
      1:       return {1'b1, ack, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1};
      2:       return 8'b0000_0001;
      3:       return {1'b0, 1'b0, 1'b0, 1'b0, aop, src, 1'b1};
      4:       return {1'b0, 1'b0, 1'b1, 1'b1, aop, src, 1'b1};
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    chk(tag, {24'h0, imem_req_o, IRWrite_o, PCWrite_o, RegWrite_o, ALUOp_o, ALUSrc_o, busy_o}, {24'h0, exp});
    chk({tag, "_w4"}, {24'h0, req4, irw4, pcw4, regw4, aluop4, src4, busy4}, {24'h0, exp});
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_ret"}, retired_o, m_ret);
    chk({tag, "_ret4"}, {28'h0, retired4}, m_ret % 16);
    chk({tag, "_flags"}, {28'h0, illegal_o, timeout_o, ill4, to4}, {28'h0, m_ill, m_to, m_ill, m_to});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; start_i = 1'b0; imem_ack_i = 1'b0;
    m_ret = 0; m_ill = 0; m_to = 0;
    #3;
    chk_ctl("reset", exp_ctl(0, 0, 0));
    chk_state("reset");
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  // From IDLE: raise start and move into FETCH.
  task automatic begin_run();
    start_i = 1'b1;
    #1 chk_ctl("idle", exp_ctl(0, 0, 0));
    tick();
  endtask

  // In FETCH: ack after `delay` stall cycles unless the watchdog expires first.
  task automatic fetch(input logic [31:0] inst, input int delay, output bit got);
    got = 0;
    for (int k = 0; k < TO; k++) begin
      imem_ack_i = (k == delay);
      inst_i     = (k == delay) ? inst : $urandom;
      #1 chk_ctl("fetch", exp_ctl(1, k == delay, 0));
      tick();
      imem_ack_i = 1'b0;
      if (k == delay) begin
        got = 1;
        break;
      end
    end
    if (!got) m_to = 1;
  endtask

  // From DECODE through WB (or into HALT on an illegal opcode).
  task automatic finish_instr(input logic [31:0] inst, input bit drop);
    bit is_r, legal;
    is_r  = (inst[6:0] == OPR);
    legal = is_r || (inst[6:0] == OPI);
    #1 chk_ctl("decode", exp_ctl(2, 0, is_r));
    tick();
    if (!legal) begin
      m_ill = 1;
      return;
    end
    if (drop) start_i = 1'b0;
    #1 chk_ctl("exec", exp_ctl(3, 0, is_r));
    tick();
    #1 chk_ctl("wb", exp_ctl(4, 0, is_r));
    tick();
    m_ret++;
    chk_state("retire");
  endtask

  task automatic run_one(input logic [31:0] inst, input int delay, input bit drop);
    bit got;
    fetch(inst, delay, got);
    if (!got) return;
    finish_instr(inst, drop);
    if (drop) begin
      for (int i = 0; i < 2; i++) begin
        #1 chk_ctl("idle_after_drop", exp_ctl(0, 0, 0));
        tick();
      end
      begin_run();
    end
  endtask

  task automatic halt_check(input string tag);
    for (int i = 0; i < 4; i++) begin
      start_i = i[0];
      #1 chk_ctl(tag, exp_ctl(0, 0, 0));
      chk_state(tag);
      tick();
    end
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], r[0] ? OPR : OPI};
  endfunction

  initial begin
    bit got;
    // reset and basic R/I instructions
    do_reset();
    begin_run();
    run_one(ADD, 0, 0);
    run_one(ADDI, 3, 0);
    run_one(ADD, 0, 1);       // start dropped in EXEC, resumes afterwards
    // randomized mix of legal instructions, stalls and start drops
    for (int n = 0; n < 20; n++)
      run_one(rand_legal(), $urandom_range(0, 5), ($urandom_range(0, 4) == 0));
    // ack in the last permitted fetch cycle still wins
    run_one(ADDI, TO - 1, 0);
    chk_state("late_ack");
    // unsupported opcode traps into HALT
    fetch(LOAD, 1, got);
    finish_instr(LOAD, 0);
    halt_check("illegal_halt");

    // fetch watchdog
    do_reset();
    begin_run();
    fetch(ADD, 1000, got);
    halt_check("timeout_halt");

    // counter wrap on the narrow instance, then async reset during WB
    do_reset();
    begin_run();
    for (int n = 0; n < 17; n++) run_one(rand_legal(), 0, 0);
    chk_state("wrap17");
    fetch(ADD, 0, got);
    #1 chk_ctl("decode_r", exp_ctl(2, 0, 1));
    tick();
    #1 chk_ctl("exec_r", exp_ctl(3, 0, 1));
    tick();
    #1 chk_ctl("wb_r", exp_ctl(4, 0, 1));
    rst_i = 1'b0;
    m_ret = 0; m_ill = 0; m_to = 0;
    #1 chk_ctl("async_rst", exp_ctl(0, 0, 0));
    chk_state("async_rst");
    tick();
    rst_i = 1'b1; start_i = 1'b0;
    tick();
    #1 chk_ctl("post_rst_idle", exp_ctl(0, 0, 0));
    chk_state("post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
